// File: rtl/sim_ctrl_regs.sv
// Simulation-control peripheral: firmware exit code/command, VCD dump trigger and a
// start/stop cycle timer, exposed through a zero-wait-state OBI slave port.
module sim_ctrl_regs #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              exit_valid_o,
  output logic [31:0]       exit_value_o,
  output logic              vcd_trig_o,
  output logic              timer_busy_o
);

  localparam logic [2:0] OFF_EXIT_VALUE = 3'd0;
  localparam logic [2:0] OFF_EXIT_CTRL  = 3'd1;
  localparam logic [2:0] OFF_TRACE      = 3'd2;
  localparam logic [2:0] OFF_TIMER_CTRL = 3'd3;
  localparam logic [2:0] OFF_TIMER_CNT  = 3'd4;
  localparam logic [2:0] OFF_SCRATCH    = 3'd5;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RUN  = 2'd1,
    T_DONE = 2'd2
  } timer_state_e;

  logic [2:0]  word_off;
  logic        addr_ok;
  logic        accept;
  logic        wr_hit;
  logic        rd_hit;
  logic [31:0] be_mask;
  logic        unused_addr_lsb;

  assign gnt_o           = req_i;
  assign accept          = req_i & gnt_o;
  assign word_off        = addr_i[4:2];
  assign unused_addr_lsb = ^addr_i[1:0];

  generate
    if (ADDR_W > 5) begin : g_upper_dec
      assign addr_ok = ~|addr_i[ADDR_W-1:5];
    end else begin : g_no_upper
      assign addr_ok = 1'b1;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_be_mask
      assign be_mask[gi*8 +: 8] = {8{be_i[gi]}};
    end
  endgenerate

  assign wr_hit = accept & we_i & addr_ok;
  assign rd_hit = accept & ~we_i;

  logic wr_exit_value;
  logic wr_exit_ctrl;
  logic wr_trace;
  logic wr_timer_ctrl;
  logic wr_scratch;

  assign wr_exit_value = wr_hit & (word_off == OFF_EXIT_VALUE);
  assign wr_exit_ctrl  = wr_hit & (word_off == OFF_EXIT_CTRL);
  assign wr_trace      = wr_hit & (word_off == OFF_TRACE);
  assign wr_timer_ctrl = wr_hit & (word_off == OFF_TIMER_CTRL);
  assign wr_scratch    = wr_hit & (word_off == OFF_SCRATCH);

  logic exit_req;
  logic timer_start;
  logic timer_stop;

  assign exit_req    = wr_exit_ctrl & be_i[0] & wdata_i[0];
  assign timer_start = wr_timer_ctrl & be_i[0] & wdata_i[0];
  assign timer_stop  = wr_timer_ctrl & be_i[0] & wdata_i[1];

  logic [31:0] exit_value_q, exit_value_d;
  logic [31:0] scratch_q, scratch_d;
  logic        trace_q, trace_d;
  logic        exit_valid_q, exit_valid_d;
  logic [31:0] exit_out_q, exit_out_d;

  always_comb begin
    exit_value_d = exit_value_q;
    scratch_d    = scratch_q;
    trace_d      = trace_q;
    exit_valid_d = exit_valid_q;
    exit_out_d   = exit_out_q;
    if (wr_exit_value) begin
      exit_value_d = (exit_value_q & ~be_mask) | (wdata_i & be_mask);
    end
    if (wr_scratch) begin
      scratch_d = (scratch_q & ~be_mask) | (wdata_i & be_mask);
    end
    if (wr_trace && be_i[0]) begin
      trace_d = wdata_i[0];
    end
    // The exit code is latched once; later exit commands cannot alter it.
    if (exit_req && !exit_valid_q) begin
      exit_valid_d = 1'b1;
      exit_out_d   = exit_value_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exit_value_q <= '0;
      scratch_q    <= '0;
      trace_q      <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_out_q   <= '0;
    end else begin
      exit_value_q <= exit_value_d;
      scratch_q    <= scratch_d;
      trace_q      <= trace_d;
      exit_valid_q <= exit_valid_d;
      exit_out_q   <= exit_out_d;
    end
  end

  timer_state_e timer_state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_state_q <= T_IDLE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (timer_state_q)
        T_IDLE: begin
          if (timer_start) begin
            timer_state_q <= T_RUN;
            cnt_q         <= '0;
            busy_q        <= 1'b1;
          end
        end
        T_RUN: begin
          // START beats STOP; the STOP cycle itself is not counted.
          if (timer_start) begin
            cnt_q <= '0;
          end else if (timer_stop) begin
            timer_state_q <= T_DONE;
            busy_q        <= 1'b0;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        T_DONE: begin
          if (timer_start) begin
            timer_state_q <= T_RUN;
            cnt_q         <= '0;
            busy_q        <= 1'b1;
          end
        end
        default: begin
          timer_state_q <= T_IDLE;
          cnt_q         <= '0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (addr_ok) begin
      case (word_off)
        OFF_EXIT_VALUE: rd_data = exit_value_q;
        OFF_EXIT_CTRL:  rd_data = {31'b0, exit_valid_q};
        OFF_TRACE:      rd_data = {31'b0, trace_q};
        OFF_TIMER_CTRL: rd_data = {29'b0, timer_state_q == T_DONE, timer_state_q == T_RUN, 1'b0};
        OFF_TIMER_CNT:  rd_data[CNT_W-1:0] = cnt_q;
        OFF_SCRATCH:    rd_data = scratch_q;
        default:        rd_data = '0;
      endcase
    end
  end

  logic        rvalid_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= accept;
      rdata_q  <= rd_hit ? rd_data : 32'b0;
    end
  end

  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rvalid_q ? rdata_q : 32'b0;
  assign exit_valid_o = exit_valid_q;
  assign exit_value_o = exit_out_q;
  assign vcd_trig_o   = trace_q;
  assign timer_busy_o = busy_q;

endmodule
